// File: rtl/sn_uart_txn_ctrl.sv
// Request/response transaction sequencer between host io logic and the sn_uart_tx/sn_uart_rx pair.
// Optional framing-fault retry is enabled by defining SN_UART_RETRY_EN.

module sn_uart_txn_ctrl #(
    parameter int P_MAX_CMD_BYTES = 4,
    parameter int P_MAX_RSP_BYTES = 4,
    parameter int P_TIMEOUT_CLKS  = 100000,
    parameter int P_MAX_RETRIES   = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [8*P_MAX_CMD_BYTES-1:0]         req_cmd,
    input  logic [$clog2(P_MAX_CMD_BYTES+1)-1:0] req_cmd_len,
    input  logic [$clog2(P_MAX_RSP_BYTES+1)-1:0] req_rsp_len,
    output logic                                 tx_start,
    output logic [7:0]                           tx_word,
    input  logic                                 tx_done,
    output logic                                 rx_enable,
    output logic                                 rx_clr,
    input  logic [7:0]                           received_word,
    input  logic                                 rx_done,
    input  logic                                 rx_active,
    output logic                                 rsp_valid,
    output logic [8*P_MAX_RSP_BYTES-1:0]         rsp_data,
    output logic [1:0]                           rsp_err,
    output logic                                 busy
);

    // state   | meaning
    // IDLE    | waiting for a host request, req_ready high
    // TX_LOAD | present next command byte, pulse tx_start
    // TX_WAIT | waiting for tx_done or timeout
    // RX_ARM  | pulse rx_enable for the next response byte
    // RX_WAIT | waiting for rx_done, framing fault or timeout
    // DONE    | pulse rsp_valid with final status

    localparam int CW  = $clog2(P_MAX_CMD_BYTES + 1);
    localparam int RW  = $clog2(P_MAX_RSP_BYTES + 1);
    localparam int TW  = (P_TIMEOUT_CLKS > 1) ? $clog2(P_TIMEOUT_CLKS) : 1;
    localparam int RTW = (P_MAX_RETRIES > 0) ? $clog2(P_MAX_RETRIES + 1) : 1;

`ifdef SN_UART_RETRY_EN
    localparam int RETRY_LIMIT = P_MAX_RETRIES;
`else
    localparam int RETRY_LIMIT = 0;
`endif

    localparam logic [TW-1:0] TO_LAST = TW'(P_TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_LOAD,
        S_TX_WAIT,
        S_RX_ARM,
        S_RX_WAIT,
        S_DONE
    } state_t;

    state_t                       state;
    logic [8*P_MAX_CMD_BYTES-1:0] cmd_q;
    logic [8*P_MAX_CMD_BYTES-1:0] cmd_sh;
    logic [CW-1:0]                cmd_len_q;
    logic [CW-1:0]                tx_rem;
    logic [RW-1:0]                rsp_len_q;
    logic [RW-1:0]                rx_idx;
    logic [TW-1:0]                to_cnt;
    logic [RTW-1:0]               retries;
    logic                         rx_active_q;

    logic [CW-1:0] cmd_len_c;
    logic [RW-1:0] rsp_len_c;
    logic          accept;
    logic          frame_fault;
    logic          to_hit;

    assign cmd_len_c   = (req_cmd_len > CW'(P_MAX_CMD_BYTES)) ? CW'(P_MAX_CMD_BYTES) : req_cmd_len;
    assign rsp_len_c   = (req_rsp_len > RW'(P_MAX_RSP_BYTES)) ? RW'(P_MAX_RSP_BYTES) : req_rsp_len;
    assign req_ready   = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign accept      = req_valid & req_ready;
    assign frame_fault = rx_active_q & ~rx_active & ~rx_done;
    assign to_hit      = (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cmd_q       <= '0;
            cmd_sh      <= '0;
            cmd_len_q   <= '0;
            tx_rem      <= '0;
            rsp_len_q   <= '0;
            rx_idx      <= '0;
            to_cnt      <= '0;
            retries     <= '0;
            rx_active_q <= 1'b0;
            tx_start    <= 1'b0;
            tx_word     <= '0;
            rx_enable   <= 1'b0;
            rx_clr      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= '0;
        end else begin
            tx_start    <= 1'b0;
            rx_enable   <= 1'b0;
            rx_clr      <= 1'b0;
            rsp_valid   <= 1'b0;
            rx_active_q <= rx_active;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd_q     <= req_cmd;
                        cmd_sh    <= req_cmd;
                        cmd_len_q <= cmd_len_c;
                        tx_rem    <= cmd_len_c;
                        rsp_len_q <= rsp_len_c;
                        rx_idx    <= '0;
                        rsp_data  <= '0;
                        rsp_err   <= 2'b00;
                        retries   <= '0;
                        if (cmd_len_c != '0)
                            state <= S_TX_LOAD;
                        else if (rsp_len_c != '0)
                            state <= S_RX_ARM;
                        else
                            state <= S_DONE;
                    end
                end

                S_TX_LOAD: begin
                    tx_word  <= cmd_sh[7:0];
                    tx_start <= 1'b1;
                    to_cnt   <= '0;
                    state    <= S_TX_WAIT;
                end

                S_TX_WAIT: begin
                    if (tx_done) begin
                        cmd_sh <= cmd_sh >> 8;
                        tx_rem <= tx_rem - CW'(1);
                        if (tx_rem != CW'(1)) begin
                            state <= S_TX_LOAD;
                        end else begin
                            rx_idx <= '0;
                            state  <= (rsp_len_q != '0) ? S_RX_ARM : S_DONE;
                        end
                    end else if (to_hit) begin
                        rsp_err <= 2'b01;
                        state   <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end

                S_RX_ARM: begin
                    rx_enable <= 1'b1;
                    to_cnt    <= '0;
                    state     <= S_RX_WAIT;
                end

                S_RX_WAIT: begin
                    // A completed byte beats a fault or timeout seen in the same cycle.
                    if (rx_done) begin
                        for (int k = 0; k < P_MAX_RSP_BYTES; k++) begin
                            if (rx_idx == RW'(k))
                                rsp_data[8*k +: 8] <= received_word;
                        end
                        rx_idx <= rx_idx + RW'(1);
                        state  <= (rx_idx == rsp_len_q - RW'(1)) ? S_DONE : S_RX_ARM;
                    end else if (frame_fault) begin
                        if (retries < RTW'(RETRY_LIMIT)) begin
                            retries  <= retries + RTW'(1);
                            rx_clr   <= 1'b1;
                            cmd_sh   <= cmd_q;
                            tx_rem   <= cmd_len_q;
                            rx_idx   <= '0;
                            rsp_data <= '0;
                            state    <= (cmd_len_q != '0) ? S_TX_LOAD : S_RX_ARM;
                        end else begin
                            rsp_err <= 2'b10;
                            state   <= S_DONE;
                        end
                    end else if (to_hit) begin
                        rsp_err <= 2'b01;
                        rx_clr  <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end

                S_DONE: begin
                    rsp_valid <= 1'b1;
                    state     <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sn_uart_txn_ctrl.sv
// Self-checking bench for sn_uart_txn_ctrl: transaction-level model plus directed scenarios.
// Expectations follow SN_UART_RETRY_EN when the bench is compiled with it.

module tb_sn_uart_txn_ctrl;

    localparam int MC     = 4;
    localparam int MR     = 4;
    localparam int TO     = 50;
    localparam int MAXRET = 2;
    localparam int A_GOOD = 0, A_FAULT = 1, A_SILENT = 2;

`ifdef SN_UART_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_cmd;
    logic [2:0]    req_cmd_len;
    logic [2:0]    req_rsp_len;
    logic          tx_start;
    logic [7:0]    tx_word;
    logic          tx_done;
    logic          rx_enable;
    logic          rx_clr;
    logic [7:0]    received_word;
    logic          rx_done;
    logic          rx_active;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic [1:0]    rsp_err;
    logic          busy;

    sn_uart_txn_ctrl #(
        .P_MAX_CMD_BYTES(MC),
        .P_MAX_RSP_BYTES(MR),
        .P_TIMEOUT_CLKS (TO),
        .P_MAX_RETRIES  (MAXRET)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_cmd_len  (req_cmd_len),
        .req_rsp_len  (req_rsp_len),
        .tx_start     (tx_start),
        .tx_word      (tx_word),
        .tx_done      (tx_done),
        .rx_enable    (rx_enable),
        .rx_clr       (rx_clr),
        .received_word(received_word),
        .rx_done      (rx_done),
        .rx_active    (rx_active),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_tx[$];
    logic [31:0] exp_data;
    int          exp_err;
    int          exp_clr;
    int          script[$];
    int          rx_q[$];
    bit          tx_mute;

    int acc_cnt = 0, done_cnt = 0;
    int tx_cnt = 0, en_cnt = 0, clr_cnt = 0, rv_cnt = 0, cyc = 0;
    int last_en_cyc = 0, last_clr_cyc = 0;
    logic [7:0] cur_tx = 8'h00;
    int d_tx, d_en, d_clr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Transmitter stand-in: finishes each byte two cycles after tx_start unless muted.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && tx_start && !tx_mute) begin
                repeat (2) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    // Receiver stand-in: each rx_enable consumes one scripted action.
    initial begin
        int item;
        rx_done = 1'b0;
        rx_active = 1'b0;
        received_word = 8'h00;
        forever begin
            @(negedge clk);
            if (rst && rx_enable && rx_q.size() > 0) begin
                item = rx_q.pop_front();
                if ((item >> 8) == A_GOOD) begin
                    rx_active = 1'b1;
                    repeat (3) @(negedge clk);
                    received_word = 8'(item);
                    rx_done = 1'b1;
                    rx_active = 1'b0;
                    @(negedge clk);
                    rx_done = 1'b0;
                end else if ((item >> 8) == A_FAULT) begin
                    rx_active = 1'b1;
                    repeat (3) @(negedge clk);
                    rx_active = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst && req_valid && acc_cnt == done_cnt)
            acc_cnt++;
    end

    // Per-cycle compare against the transaction model.
    always @(negedge clk) begin
        bit exp_busy;
        cyc++;
        if (!rst) begin
            done_cnt = acc_cnt;
        end else begin
            exp_busy = (acc_cnt != done_cnt);
            if (rsp_valid) begin
                rv_cnt++;
                chk("rsp_valid_expected", {31'b0, rsp_valid}, {31'b0, exp_busy});
                if (exp_busy) begin
                    chk("rsp_data", rsp_data, exp_data);
                    chk("rsp_err", {30'b0, rsp_err}, 32'(exp_err));
                    done_cnt++;
                end
                chk("busy_at_rsp", {31'b0, busy}, 32'd0);
            end else begin
                chk("busy", {31'b0, busy}, {31'b0, exp_busy});
                chk("req_ready", {31'b0, req_ready}, {31'b0, ~exp_busy});
            end
            if (tx_start) begin
                tx_cnt++;
                if (exp_tx.size() == 0) begin
                    fail_now("unexpected_tx_start");
                end else begin
                    cur_tx = exp_tx.pop_front();
                    chk("tx_word", {24'b0, tx_word}, {24'b0, cur_tx});
                end
            end
            if (tx_done)
                chk("tx_word_held", {24'b0, tx_word}, {24'b0, cur_tx});
            if (rx_enable) begin
                en_cnt++;
                last_en_cyc = cyc;
            end
            if (rx_clr) begin
                clr_cnt++;
                last_clr_cyc = cyc;
            end
        end
    end

    // Transaction-level expectation: bytes sent, bytes kept, final status.
    task automatic model_txn(input logic [31:0] cmd, input int cl, input int rl);
        int c, r, pos, retries, act;
        bit fin;
        logic [7:0] val;
        c = (cl > MC) ? MC : cl;
        r = (rl > MR) ? MR : rl;
        exp_tx.delete();
        exp_data = '0;
        exp_err = 0;
        exp_clr = 0;
        retries = 0;
        pos = 0;
        fin = 0;
        if (tx_mute && c > 0) begin
            exp_tx.push_back(cmd[7:0]);
            exp_err = 1;
            fin = 1;
        end
        while (!fin) begin
            exp_data = '0;
            fin = 1;
            for (int i = 0; i < c; i++) exp_tx.push_back(cmd[8*i +: 8]);
            for (int k = 0; k < r; k++) begin
                val = 8'h00;
                act = A_SILENT;
                if (pos < script.size()) begin
                    act = script[pos] >> 8;
                    val = 8'(script[pos]);
                end
                pos++;
                if (act == A_GOOD) begin
                    exp_data[8*k +: 8] = val;
                end else if (act == A_FAULT) begin
                    if (RETRY && retries < MAXRET) begin
                        retries++;
                        exp_clr++;
                        fin = 0;
                    end else begin
                        exp_err = 2;
                    end
                    break;
                end else begin
                    exp_err = 1;
                    exp_clr++;
                    break;
                end
            end
        end
    endtask

    task automatic run_txn(input logic [31:0] cmd, input int cl, input int rl, input bit poke,
                           output int lat);
        int s_tx, s_en, s_clr, n_tx;
        model_txn(cmd, cl, rl);
        n_tx = exp_tx.size();
        rx_q = script;
        s_tx = tx_cnt;
        s_en = en_cnt;
        s_clr = clr_cnt;
        @(negedge clk);
        req_cmd = cmd;
        req_cmd_len = 3'(cl);
        req_rsp_len = 3'(rl);
        req_valid = 1'b1;
        lat = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            if (poke && i == 4) begin
                req_valid = 1'b1;
                req_cmd = 32'hFFFF_FFFF;
                req_cmd_len = 3'd1;
            end else begin
                req_valid = 1'b0;
            end
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        req_valid = 1'b0;
        if (lat == 0) fail_now("rsp_valid_wait");
        @(posedge clk);
        #1;
        d_tx = tx_cnt - s_tx;
        d_en = en_cnt - s_en;
        d_clr = clr_cnt - s_clr;
        chk("tx_count_model", 32'(d_tx), 32'(n_tx));
        chk("rx_clr_count_model", 32'(d_clr), 32'(exp_clr));
        chk("tx_bytes_left", 32'(exp_tx.size()), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctl"}, {26'b0, tx_start, rx_enable, rx_clr, rsp_valid, busy, req_ready}, 32'h1);
        chk({tag, "_data"}, rsp_data, 32'h0);
        chk({tag, "_err"}, {30'b0, rsp_err}, 32'h0);
        chk({tag, "_tx_word"}, {24'b0, tx_word}, 32'h0);
    endtask

    initial begin
        int lat, s_rv;
        bit seen;
        rst = 1'b1;
        req_valid = 1'b0;
        req_cmd = '0;
        req_cmd_len = '0;
        req_rsp_len = '0;
        tx_mute = 1'b0;
        exp_data = '0;
        exp_err = 0;
        exp_clr = 0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b1;

        // 1: two command bytes, one response byte; a stray request mid-transaction is ignored
        script = '{(A_GOOD << 8) | 8'h5A};
        run_txn(32'h0000_3CA5, 2, 1, 1'b1, lat);
        chk("t1_data", rsp_data, 32'h0000_005A);
        chk("t1_err", {30'b0, rsp_err}, 32'd0);
        chk("t1_last_tx_word", {24'b0, tx_word}, 32'h3C);
        chk("t1_tx_count", 32'(d_tx), 32'd2);

        // 2: empty transaction
        script = {};
        run_txn(32'h0, 0, 0, 1'b0, lat);
        chk("t2_latency", 32'(lat), 32'd2);
        chk("t2_tx_starts", 32'(d_tx), 32'd0);
        chk("t2_rx_enables", 32'(d_en), 32'd0);
        chk("t2_err", {30'b0, rsp_err}, 32'd0);

        // 3: receiver silent -> timeout with rx_clr
        script = '{(A_SILENT << 8)};
        run_txn(32'h0000_00AB, 0, 1, 1'b0, lat);
        chk("t3_err", {30'b0, rsp_err}, 32'd1);
        chk("t3_wait_clks", 32'(last_clr_cyc - last_en_cyc), 32'(TO));
        chk("t3_latency", 32'(lat), 32'd53);
        chk("t3_rx_clr", 32'(d_clr), 32'd1);

        // 4: framing faults only
        script = '{(A_FAULT << 8), (A_FAULT << 8), (A_FAULT << 8)};
        run_txn(32'h0000_0042, 1, 1, 1'b0, lat);
        chk("t4_err", {30'b0, rsp_err}, 32'd2);
        chk("t4_data", rsp_data, 32'h0);
        chk("t4_tx_count", 32'(d_tx), RETRY ? 32'd3 : 32'd1);

        // 5: two faults then a good byte
        script = '{(A_FAULT << 8), (A_FAULT << 8), (A_GOOD << 8) | 8'h11};
        run_txn(32'h0000_0077, 1, 1, 1'b0, lat);
        chk("t5_err", {30'b0, rsp_err}, RETRY ? 32'd0 : 32'd2);
        chk("t5_data", rsp_data, RETRY ? 32'h11 : 32'h0);
        chk("t5_tx_count", 32'(d_tx), RETRY ? 32'd3 : 32'd1);

        // lengths above max clamp to 4
        script = '{(A_GOOD << 8) | 8'hAA, (A_GOOD << 8) | 8'hBB, (A_GOOD << 8) | 8'hCC,
                   (A_GOOD << 8) | 8'hDD};
        run_txn(32'h4433_2211, 7, 7, 1'b0, lat);
        chk("clamp_data", rsp_data, 32'hDDCC_BBAA);
        chk("clamp_tx_count", 32'(d_tx), 32'd4);
        chk("clamp_rx_enables", 32'(d_en), 32'd4);

        // command only
        script = {};
        run_txn(32'h0000_BEEF, 2, 0, 1'b0, lat);
        chk("txonly_err", {30'b0, rsp_err}, 32'd0);
        chk("txonly_rx_enables", 32'(d_en), 32'd0);
        chk("txonly_data", rsp_data, 32'h0);

        // fault on third byte keeps the earlier bytes
        script = '{(A_GOOD << 8) | 8'h01, (A_GOOD << 8) | 8'h02, (A_FAULT << 8),
                   (A_GOOD << 8) | 8'h01, (A_GOOD << 8) | 8'h02, (A_FAULT << 8),
                   (A_GOOD << 8) | 8'h01, (A_GOOD << 8) | 8'h02, (A_FAULT << 8)};
        run_txn(32'h0, 0, 3, 1'b0, lat);
        chk("partial_err", {30'b0, rsp_err}, 32'd2);
        chk("partial_data", rsp_data, 32'h0000_0201);

        // transmitter never finishes -> timeout, no rx_clr
        tx_mute = 1'b1;
        script = {};
        run_txn(32'h0000_0099, 1, 1, 1'b0, lat);
        chk("txto_err", {30'b0, rsp_err}, 32'd1);
        chk("txto_latency", 32'(lat), 32'd53);
        chk("txto_rx_clr", 32'(d_clr), 32'd0);

        // 6: reset while waiting on the transmitter
        script = {};
        rx_q = {};
        exp_tx.delete();
        exp_tx.push_back(8'h5C);
        exp_data = 32'h0;
        exp_err = 0;
        @(negedge clk);
        req_cmd = 32'h0000_005C;
        req_cmd_len = 3'd1;
        req_rsp_len = 3'd0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_start) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) fail_now("t6_tx_start_wait");
        repeat (3) @(negedge clk);
        chk("t6_busy_before", {31'b0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check_reset("t6");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tx_mute = 1'b0;
        s_rv = rv_cnt;
        repeat (TO + 10) @(negedge clk);
        chk("t6_no_rsp_valid", 32'(rv_cnt - s_rv), 32'd0);
        chk("t6_idle_after", {30'b0, busy, req_ready}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
